// File: rtl/mem_bist_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_bist_pkg
// Shared types for the DataMemory march-test controller: the top-level test
// state, the read/write phase used by the two-access march elements, and the
// address walk direction handed to the address generator.
// ---------------------------------------------------------------------------
package mem_bist_pkg;

  // March elements in execution order; DONE holds the result until restart.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0W1 = 3'd2,
    R1W0 = 3'd3,
    R0   = 3'd4,
    DONE = 3'd5
  } bist_state_e;

  // Read-then-write elements spend one cycle in each phase per address.
  typedef enum logic {
    RD_PH = 1'b0,
    WR_PH = 1'b1
  } bist_phase_e;

  // Address walk direction of the current march element.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } bist_dir_e;

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl_if
// Single-port DataMemory access bundle used by the BIST controller.
//   mem_we  write enable          (master -> memory)
//   mem_a   word address          (master -> memory)
//   mem_wd  write data            (master -> memory)
//   mem_rd  read data, combinational from mem_a (memory -> master)
// ---------------------------------------------------------------------------
interface mem_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport master (output mem_we, output mem_a, output mem_wd, input mem_rd);
  modport slave  (input mem_we, input mem_a, input mem_wd, output mem_rd);

endinterface

// File: rtl/mem_bist_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// mem_bist_addr_gen
// Loadable up/down address counter for the march walk.
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      restart the walk at the first address of direction dir_i
//   dir_i       walk direction latched on load_i
//   step_i      advance one address in the latched direction
//   addr_o      current address
//   first_o     addr_o is the first address of the current walk
//   last_o      addr_o is the final address of the current walk
// The controller turns to the next element on last_o, so the counter is
// never relied on to wrap.
// ---------------------------------------------------------------------------
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  bist_dir_e             dir_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  first_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  bist_dir_e             dir_q, dir_d;

  // Load has priority over step so a new element always starts cleanly.
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    if (load_i) begin
      dir_d  = dir_i;
      addr_d = (dir_i == UP) ? '0 : ADDR_MAX;
    end else if (step_i) begin
      addr_d = (dir_q == UP) ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      dir_q  <= UP;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
    end
  end

  assign addr_o  = addr_q;
  assign first_o = (dir_q == UP) ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last_o  = (dir_q == UP) ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/mem_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl
// March-test initiator for DataMemory: W0 (up), R0W1 (up), R1W0 (down),
// R0 (up) using PATTERN and its inverse. Stops at the first mismatch.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch request, honoured only in IDLE or DONE
//   busy         test in progress
//   done         test finished, held until the next start
//   pass         valid with done: 1 = no mismatch seen
//   fail_addr    first mismatching address (0 on pass)
//   fail_exp     expected word at fail_addr
//   fail_got     word read at fail_addr
//   mem          master side of the DataMemory port (mem_we/mem_a/mem_wd/mem_rd)
// ---------------------------------------------------------------------------
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 16'hAAAA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  mem_bist_ctrl_if.master       mem
);

  localparam logic [DATA_WIDTH-1:0] PAT_INV = ~PATTERN;

  bist_state_e           state_q, state_d;
  bist_phase_e           phase_q, phase_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0] fail_got_q, fail_got_d;

  logic                  load, step;
  bist_dir_e             load_dir;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_first, addr_last;
  logic                  check;
  logic [DATA_WIDTH-1:0] exp_word;

  mem_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .dir_i   (load_dir),
    .step_i  (step),
    .addr_o  (addr),
    .first_o (addr_first),
    .last_o  (addr_last)
  );

  // Next-state and memory-port decode. Reads are combinational, so the
  // compare is done in the same cycle mem_a is driven; a mismatch jumps
  // straight to DONE without issuing the pending write.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    load        = 1'b0;
    load_dir    = UP;
    step        = 1'b0;
    check       = 1'b0;
    exp_word    = PATTERN;
    mem.mem_we  = 1'b0;
    mem.mem_a   = '0;
    mem.mem_wd  = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = W0;
          phase_d     = RD_PH;
          load        = 1'b1;
          load_dir    = UP;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
        end
      end
      W0: begin
        mem.mem_a  = addr;
        mem.mem_we = 1'b1;
        mem.mem_wd = PATTERN;
        if (addr_last) begin
          state_d = R0W1;
          load    = 1'b1;
          load_dir = UP;
        end else begin
          step = 1'b1;
        end
      end
      R0W1, R1W0: begin
        mem.mem_a = addr;
        if (phase_q == RD_PH) begin
          check    = 1'b1;
          exp_word = (state_q == R0W1) ? PATTERN : PAT_INV;
          if (mem.mem_rd == exp_word) begin
            phase_d = WR_PH;
          end
        end else begin
          mem.mem_we = 1'b1;
          mem.mem_wd = (state_q == R0W1) ? PAT_INV : PATTERN;
          phase_d    = RD_PH;
          if (addr_last) begin
            state_d  = (state_q == R0W1) ? R1W0 : R0;
            load     = 1'b1;
            load_dir = (state_q == R0W1) ? DOWN : UP;
          end else begin
            step = 1'b1;
          end
        end
      end
      R0: begin
        mem.mem_a = addr;
        check     = 1'b1;
        exp_word  = PATTERN;
        if (mem.mem_rd == exp_word) begin
          if (addr_last) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (check && (mem.mem_rd != exp_word)) begin
      state_d     = DONE;
      pass_d      = 1'b0;
      fail_addr_d = addr;
      fail_exp_d  = exp_word;
      fail_got_d  = mem.mem_rd;
    end
  end

  // State, phase and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= RD_PH;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

  // Every element begins at its first address the cycle after a load.
  a_first_after_load: assert property (@(posedge clk) disable iff (!rst_n) load |=> addr_first);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_bist_ctrl
// Bench for mem_bist_ctrl with a 16-word behavioural DataMemory that can
// model a stuck-at-1 bit (addr 5, bit 0) or an address alias (7 -> 3).
// A table of fault scenarios is run first, followed by multi-cycle
// sequences: mid-run reset, ignored start pulses and restart from DONE.
// ---------------------------------------------------------------------------
module tb_mem_bist_ctrl;

  localparam int              AW   = 4;
  localparam int              DW   = 16;
  localparam int              N    = 16;
  localparam logic [DW-1:0]   PAT  = 16'hAAAA;
  localparam logic [DW-1:0]   PINV = 16'h5555;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;

  int checks = 0;
  int errors = 0;

  mem_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memIf ();

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(PAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .mem       (memIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMemory: synchronous write, combinational read.
  // faultMode 0 = clean, 1 = addr 5 bit 0 stuck at 1, 2 = addr 7 aliases addr 3.
  logic [DW-1:0] memArr [N];
  int            faultMode;
  int            writesTo5;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdVal;

  function automatic logic [AW-1:0] physAddr(input logic [AW-1:0] a, input int mode);
    return (mode == 2 && a == 4'd7) ? 4'd3 : a;
  endfunction

  always @(posedge clk) begin
    if (memIf.mem_we) begin
      memArr[physAddr(memIf.mem_a, faultMode)] = memIf.mem_wd;
      if (memIf.mem_a == 4'd5) writesTo5++;
    end
  end

  always_comb begin
    rdAddr = physAddr(memIf.mem_a, faultMode);
    rdVal  = memArr[rdAddr];
    if (faultMode == 1 && memIf.mem_a == 4'd5) rdVal[0] = 1'b1;
    memIf.mem_rd = rdVal;
  end

  typedef struct {
    string         name;
    int            fault;
    logic          expPass;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expExp;
    logic [DW-1:0] expGot;
    int            expBusy;
    int            expWr5;
  } vec_t;

  vec_t vecs [3];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < N; i++) memArr[i] = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Launch (start held for holdCycles edges), optionally pulse start again
  // after pokeA/pokeB busy cycles, follow the run to done with a cycle
  // bound, and compare every busy cycle's memory access with the march order.
  task automatic runBist(input int holdCycles, input int pokeA, input int pokeB,
                         output int busyCycles, output logic firstDone, output logic finished);
    int            seqErr;
    int            idx;
    logic          expWe;
    logic [AW-1:0] expA;
    logic [DW-1:0] expWd;
    seqErr     = 0;
    busyCycles = 0;
    finished   = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    firstDone = done;
    for (int t = 0; t < 400; t++) begin
      if (done && busyCycles > 0) begin
        finished = 1'b1;
        break;
      end
      if (busy) begin
        if (busyCycles < 16) begin
          expWe = 1'b1; expA = AW'(busyCycles); expWd = PAT;
        end else if (busyCycles < 48) begin
          idx = busyCycles - 16;
          expWe = idx[0]; expA = AW'(idx / 2); expWd = expWe ? PINV : '0;
        end else if (busyCycles < 80) begin
          idx = busyCycles - 48;
          expWe = idx[0]; expA = AW'(15 - idx / 2); expWd = expWe ? PAT : '0;
        end else begin
          expWe = 1'b0; expA = AW'(busyCycles - 80); expWd = '0;
        end
        if (memIf.mem_we !== expWe || memIf.mem_a !== expA || memIf.mem_wd !== expWd) seqErr++;
        busyCycles++;
      end else if (memIf.mem_we !== 1'b0) begin
        seqErr++;
      end
      if (!memIf.mem_we && memIf.mem_wd !== '0) seqErr++;
      start = (t < holdCycles - 1) || (busyCycles == pokeA) || (busyCycles == pokeB);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("memSeq", seqErr, 0);
  endtask

  // One table scenario: fresh memory, reset, full run, result compare.
  task automatic applyStimulus(input vec_t v);
    int   cyc;
    int   bad;
    logic fd, fin;
    clearMem();
    faultMode = v.fault;
    writesTo5 = 0;
    resetDut();
    runBist(1, -1, -1, cyc, fd, fin);
    checkOutput({v.name, ".finished"}, fin, 1);
    checkOutput({v.name, ".busyCycles"}, cyc, v.expBusy);
    checkOutput({v.name, ".done"}, done, 1);
    checkOutput({v.name, ".busy"}, busy, 0);
    checkOutput({v.name, ".pass"}, pass, v.expPass);
    checkOutput({v.name, ".fail_addr"}, fail_addr, v.expAddr);
    checkOutput({v.name, ".fail_exp"}, fail_exp, v.expExp);
    checkOutput({v.name, ".fail_got"}, fail_got, v.expGot);
    checkOutput({v.name, ".writesTo5"}, writesTo5, v.expWr5);
    checkOutput({v.name, ".weAfterDone"}, memIf.mem_we, 0);
    if (v.fault == 0) begin
      bad = 0;
      for (int i = 0; i < N; i++) if (memArr[i] !== PAT) bad++;
      checkOutput({v.name, ".finalContents"}, bad, 0);
    end
  endtask

  initial begin
    int   cyc;
    logic fd, fin;

    vecs[0] = '{"clean",   0, 1'b1, 4'd0, 16'h0000, 16'h0000, 96, 3};
    vecs[1] = '{"stuck5",  1, 1'b0, 4'd5, 16'hAAAA, 16'hAAAB, 27, 1};
    vecs[2] = '{"alias73", 2, 1'b0, 4'd7, 16'hAAAA, 16'h5555, 31, 2};

    faultMode = 0;
    writesTo5 = 0;
    clearMem();
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.pass", pass, 0);
    checkOutput("rst.fail_addr", fail_addr, 0);
    checkOutput("rst.fail_exp", fail_exp, 0);
    checkOutput("rst.fail_got", fail_got, 0);
    checkOutput("rst.mem_we", memIf.mem_we, 0);
    checkOutput("rst.mem_wd", memIf.mem_wd, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) applyStimulus(vecs[v]);

    // Reset asserted mid-cycle on an R0W1 write cycle around busy cycle 40.
    $display("[TB] mid-run reset");
    faultMode = 0;
    clearMem();
    resetDut();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int t = 0; t < 200; t++) begin
      if (busy) cyc++;
      if (cyc == 42) break;
      @(negedge clk);
    end
    checkOutput("midRst.reached", cyc, 42);
    checkOutput("midRst.weBefore", memIf.mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.mem_we", memIf.mem_we, 0);
    checkOutput("midRst.mem_wd", memIf.mem_wd, 0);
    checkOutput("midRst.busy", busy, 0);
    checkOutput("midRst.done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midRst.weHeld", memIf.mem_we, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midRst.idleDone", done, 0);
    runBist(1, -1, -1, cyc, fd, fin);
    checkOutput("afterRst.finished", fin, 1);
    checkOutput("afterRst.busyCycles", cyc, 96);
    checkOutput("afterRst.pass", pass, 1);

    // Start pulses while busy must not disturb the run.
    $display("[TB] start while busy");
    runBist(1, 10, 50, cyc, fd, fin);
    checkOutput("pokes.finished", fin, 1);
    checkOutput("pokes.busyCycles", cyc, 96);
    checkOutput("pokes.pass", pass, 1);

    // Start held high in DONE clears done on the next edge and reruns.
    $display("[TB] restart from done");
    runBist(3, -1, -1, cyc, fd, fin);
    checkOutput("restart.doneCleared", fd, 0);
    checkOutput("restart.finished", fin, 1);
    checkOutput("restart.busyCycles", cyc, 96);
    checkOutput("restart.pass", pass, 1);
    checkOutput("restart.fail_addr", fail_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
